spi_adc_responder: RTL
======================

# spi_adc_responder

SPI peripheral that emulates one receive-channel ADC, the far end of the sonar ADC readout link. It accepts 16-bit samples from a sample source over a valid/ready handshake, holds one sample, and shifts it out MSB-first on `chip_data_out` when the SPI controller frames a read with chip-select and data clock. It replaces a physical ADC in loopback benches and on-board echo-injection tests, feeding `spi_con` with known waveforms.

## Interface

Parameters:
- `DATA_WIDTH`, 16: bits per frame and sample width.
- `SYNC_STAGES`, 2: synchronizer flops on `chip_clk_in` and `chip_sel_in`, minimum 2.

Ports:
- `clk_in` input, 1: system clock, 100 MHz.
- `rst_in` input, 1: asynchronous, active-low reset.
- `sample_in` input, DATA_WIDTH: next sample to serve.
- `sample_valid_in` input, 1: `sample_in` valid.
- `sample_ready_out` output, 1: holding register empty.
- `chip_clk_in` input, 1: SPI data clock from the controller, CPOL=0.
- `chip_sel_in` input, 1: SPI chip-select, active-low.
- `chip_data_out` output, 1: serial data (CIPO).
- `chip_data_oe_out` output, 1: high while selected; pad tristates when low.
- `frame_done_out` output, 1: one-cycle pulse on completed frame.
- `underrun_out` output, 1: one-cycle pulse when a frame starts with the holding register empty.

## Operation

- Handshake: accept when `sample_valid_in && sample_ready_out`, write holding register, set full. A full holding register ignores valid.
- Synchronized `chip_clk_in` and `chip_sel_in` give edge strobes: `cs_fall`, `cs_rise`, `sclk_rise`, `sclk_fall`.
- FSM states: IDLE, SHIFT, DONE.
  - **IDLE**, on `cs_fall`:
    - Holding full: load the shift register from holding, clear full, copy the word into `last_word`.
    - Holding empty: load `last_word` and pulse `underrun_out`.
    - Set `bit_cnt` = 0 and go to SHIFT.
  - **SHIFT**:
    - `chip_data_out` = shift-register MSB.
    - On `sclk_fall`, shift left with zero fill.
    - On `sclk_rise`, `bit_cnt`++. Reaching DATA_WIDTH moves to DONE.
  - **DONE**:
    - Drive 0 for any extra clocks.
    - On `cs_rise`, pulse `frame_done_out` and go to IDLE.
- `cs_rise` in SHIFT aborts the frame: go to IDLE, no `frame_done_out`. The consumed sample is not restored.
- `chip_data_oe_out` = synchronized chip-select active, in every state.
- An accept in the same cycle as `cs_fall` with the holding register empty is an underrun. The new sample stays in holding for the next frame; there is no bypass path.
- `bit_cnt` width is $clog2(DATA_WIDTH+1).

## Timing

- Reset values:
  - `chip_data_out` 0, `chip_data_oe_out` 0.
  - `sample_ready_out` 1.
  - `frame_done_out` 0, `underrun_out` 0.
  - `last_word` 0, state IDLE.
- `sample_ready_out` falls the cycle after an accept and rises the cycle after a load.
- Latency from a pad edge to its strobe is SYNC_STAGES cycles. The MSB appears on `chip_data_out` SYNC_STAGES+1 cycles after chip-select falls.
- Data changes SYNC_STAGES+1 cycles after an SCLK falling edge.
- Controller constraints for correct data:
  - SCLK half-period ≥ SYNC_STAGES+2 cycles.
  - Chip-select fall to first SCLK rise ≥ SYNC_STAGES+2 cycles.
  - Benches use DATA_CLK_PERIOD ≥ 8 on `spi_con`.
- `frame_done_out` and `underrun_out` are exactly one cycle wide.
- Reset assertion mid-frame forces all reset values immediately, asynchronously.

## Configuration

- `SPI_RESP_TEST_PATTERN_EN` defined:
  - An internal DATA_WIDTH ramp counter, reset 0, replaces `last_word` on underrun.
  - The ramp increments after each underrun load and wraps from all-ones to 0.
  - `underrun_out` still pulses.
- Undefined: no counter is built, and underrun resends `last_word`.

## Structure

- Package `spi_resp_pkg` holds:
  - State enum `spi_resp_state_t` (IDLE, SHIFT, DONE).
  - Default width constant `SPI_RESP_DATA_WIDTH` = 16.
- Sub-module `sync_edge_det`: an N-stage synchronizer with rise and fall strobes, instantiated twice (SCLK, chip-select).

## Test plan

- **Single frame:** push 16'hA5C3, frame 16 clocks at period 10 → controller reads 16'hA5C3. `frame_done_out` pulses once after chip-select rises; `sample_ready_out` returns to 1.
- **Underrun:** frame with holding empty after a served 16'h1234 → reads 16'h1234 and `underrun_out` pulses once. With `SPI_RESP_TEST_PATTERN_EN`, it reads 16'h0000, then 16'h0001 on the next underrun.
- **Back-pressure:** valid held high with 16'h0001 then 16'h0002 → only 16'h0001 accepted until a frame loads it. Two frames read 16'h0001, then 16'h0002.
- **Abort:** chip-select rises after 7 SCLK rising edges → no `frame_done_out`. The next frame serves the next holding sample or `last_word`.
- **Overclock:** 20 SCLK pulses in one frame → the first 16 bits are correct, extra bits read 0, `frame_done_out` pulses once.
- **Async reset mid-SHIFT** → the cycle after `rst_in` falls, outputs are at reset values. After release, ready=1 and state is IDLE.

Source files
------------

// File: rtl/spi_resp_pkg.sv
// Shared types and constants for the SPI ADC responder.
package spi_resp_pkg;

  localparam int unsigned SPI_RESP_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } spi_resp_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// N-stage synchronizer for an asynchronous pad input with single-cycle rise/fall strobes.
// The strobes assert STAGES cycles after the pad edge. STAGES must be at least 2.
module sync_edge_det #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic pad,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Synchronizer chain plus one delayed copy of its output for edge detection
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pad};
      prev_q <= sync_q[STAGES-1];
    end
  end

  // Edge strobes from the synchronized level and its previous value
  always_comb begin
    rise = sync_q[STAGES-1] & ~prev_q;
    fall = ~sync_q[STAGES-1] & prev_q;
  end

endmodule

// File: rtl/spi_adc_responder.sv
// SPI peripheral emulating one ADC receive channel: holds one sample taken over a
// valid/ready handshake and shifts it out MSB-first (SPI mode 0) when the controller
// frames a read. Optional build macro SPI_RESP_TEST_PATTERN_EN replaces the underrun
// resend of the last served word with an incrementing ramp.
module spi_adc_responder
  import spi_resp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = SPI_RESP_DATA_WIDTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid_in,
  output logic                  sample_ready_out,
  input  logic                  chip_clk_in,
  input  logic                  chip_sel_in,
  output logic                  chip_data_out,
  output logic                  chip_data_oe_out,
  output logic                  frame_done_out,
  output logic                  underrun_out
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  spi_resp_state_t state_q, state_d;

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  logic [DATA_WIDTH-1:0] hold_q;
  logic                  full_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic                  oe_q;
  logic                  frame_done_q;
  logic                  underrun_q;
  logic [DATA_WIDTH-1:0] underrun_word;

  logic accept, load_en, underrun_ev, shift_en, count_en, done_ev;

  sync_edge_det #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b0)
  ) u_sync_sclk (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .pad   (chip_clk_in),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  // Chip-select idles high, so its synchronizer resets high to avoid a false fall
  sync_edge_det #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b1)
  ) u_sync_cs (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .pad   (chip_sel_in),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  // FSM state register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; chip-select release always wins and aborts a partial frame
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (cs_fall) state_d = StShift;
      end
      StShift: begin
        if (cs_rise) begin
          state_d = StIdle;
        end else if (sclk_rise && (bit_cnt_q == CNT_LAST)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (cs_rise) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs and datapath controls
  always_comb begin
    sample_ready_out = ~full_q;
    accept           = sample_valid_in & ~full_q;
    load_en          = (state_q == StIdle) & cs_fall;
    underrun_ev      = load_en & ~full_q;
    shift_en         = (state_q == StShift) & sclk_fall;
    count_en         = (state_q == StShift) & sclk_rise;
    done_ev          = (state_q == StDone) & cs_rise;
    chip_data_out    = (state_q == StShift) ? shift_q[DATA_WIDTH-1] : 1'b0;
    chip_data_oe_out = oe_q;
    frame_done_out   = frame_done_q;
    underrun_out     = underrun_q;
  end

  // Holding register: an accept coincident with a frame start stays for the next frame
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hold_q <= '0;
      full_q <= 1'b0;
    end else if (accept) begin
      hold_q <= sample_in;
      full_q <= 1'b1;
    end else if (load_en) begin
      full_q <= 1'b0;
    end
  end

`ifdef SPI_RESP_TEST_PATTERN_EN
  logic [DATA_WIDTH-1:0] ramp_q;

  // Ramp word served on underrun, advancing once per underrun load
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ramp_q <= '0;
    end else if (underrun_ev) begin
      ramp_q <= ramp_q + DATA_WIDTH'(1);
    end
  end

  // Underrun source selection
  always_comb begin
    underrun_word = ramp_q;
  end
`else
  logic [DATA_WIDTH-1:0] last_word_q;

  // Copy of the most recently served fresh sample, resent on underrun
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      last_word_q <= '0;
    end else if (load_en && full_q) begin
      last_word_q <= hold_q;
    end
  end

  // Underrun source selection
  always_comb begin
    underrun_word = last_word_q;
  end
`endif

  // Shift register and bit counter
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else if (load_en) begin
      shift_q   <= full_q ? hold_q : underrun_word;
      bit_cnt_q <= '0;
    end else begin
      if (shift_en) shift_q <= {shift_q[DATA_WIDTH-2:0], 1'b0};
      if (count_en) bit_cnt_q <= bit_cnt_q + CNT_ONE;
    end
  end

  // Registered pad enable and single-cycle event pulses
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      oe_q         <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      if (cs_fall) begin
        oe_q <= 1'b1;
      end else if (cs_rise) begin
        oe_q <= 1'b0;
      end
      frame_done_q <= done_ev;
      underrun_q   <= underrun_ev;
    end
  end

endmodule
